uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` byte transmitter among `NUM_REQ` requesters. It sits between several byte producers (status reporter, debug dump, command responder, …) and the single UART TX port. It grants the transmitter per packet, not per byte: a granted requester keeps the port until it sends a byte flagged `last`, or until it stalls for longer than `LOCK_TIMEOUT` cycles. It drives `uart_tx_en`/`uart_tx_data` and paces itself from `uart_tx_busy`.

---
 rtl/uart_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte transmitter
// among NUM_REQ byte producers, with an idle-owner lock timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 lock_timeout
);

    localparam int          PW        = $clog2(NUM_REQ);
    localparam logic [15:0] HOLD_LAST = 16'(LOCK_TIMEOUT - 1);

    typedef logic [PW-1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_d;
    idx_t        rr_ptr;
    idx_t        owner;
    idx_t        owner_inc;
    idx_t        arb_idx;
    idx_t        cap_idx;
    logic        last_r;
    logic [15:0] hold_cnt;

    logic        capture;
    logic        release_gnt;
    logic        timeout_d;
    logic        hold_clr;
    logic        hold_inc;
    logic [7:0]  cap_data;
    logic        cap_last;

    // Modulo-NUM_REQ add; also correct when NUM_REQ is not a power of two.
    function automatic idx_t wrap_add(input idx_t base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return idx_t'(s);
    endfunction

    assign owner_inc = wrap_add(owner, 1);

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        arb_idx = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) begin
                arb_idx = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        cap_data = 8'h00;
        cap_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(cap_idx) == i) begin
                cap_data = req_data[i*8 +: 8];
                cap_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state and datapath registers use non-blocking assignments so
        // every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        release_gnt = 1'b0;
        timeout_d   = 1'b0;
        hold_clr    = 1'b0;
        hold_inc    = 1'b0;
        cap_idx     = owner;

        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    capture = 1'b1;
                    cap_idx = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_r) begin
                        release_gnt = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        hold_clr = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                // A byte arriving on the final hold cycle beats the timeout.
                if (req_valid[owner]) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end else if (hold_cnt == HOLD_LAST) begin
                    timeout_d   = 1'b1;
                    release_gnt = 1'b1;
                    state_d     = IDLE;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: only control and datapath registers live here; all of them
        // take a defined reset value, there is no storage array to exempt.
        if (!rst_n) begin
            gnt          <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            uart_tx_data <= 8'h00;
            last_r       <= 1'b0;
            hold_cnt     <= 16'h0000;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= timeout_d;

            if (capture) begin
                gnt          <= NUM_REQ'(1) << cap_idx;
                owner        <= cap_idx;
                uart_tx_data <= cap_data;
                last_r       <= cap_last;
            end else if (release_gnt) begin
                gnt    <= '0;
                rr_ptr <= owner_inc;
            end

            if (hold_clr) begin
                hold_cnt <= 16'h0000;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + 16'h0001;
            end
        end
    end

    // Strobes are decoded from registered state only.
    assign uart_tx_en = (state == LOAD);
    assign req_ready  = (state == LOAD) ? gnt : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table-driven arbitration vectors,
// directed packet/timeout/reset sequences and a randomized packet scoreboard.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int LT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          uart_tx_en;
    logic [7:0]    uart_tx_data;
    logic          busy;
    logic [N-1:0]  gnt;
    logic          lock_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int lt_seen = 0;
    int busy_cnt;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (busy),
        .gnt          (gnt),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // Stand-in for uart_tx: busy rises the edge after en and lasts a frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            busy_cnt <= 0;
        end else if (uart_tx_en) begin
            busy     <= 1'b1;
            busy_cnt <= int'($urandom_range(14, 4));
        end else if (busy) begin
            if (busy_cnt == 0) busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          n;
        logic [15:0] order;
    } vec_t;

    vec_t vecs [8];

    logic [7:0] str_data [N][16];
    bit         str_last [N][16];
    int         slen [N];
    int         spos [N];
    int         sgap [N];
    int         exp_idx [64];
    logic [7:0] exp_data [64];
    int         n_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (lock_timeout) lt_seen++;
    endtask

    task automatic wait_en(input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!uart_tx_en && waited < budget);
        check("en_seen", 32'(uart_tx_en), 32'd1);
    endtask

    task automatic wait_frame();
        int w;
        w = 0;
        while (!busy && w < 50) begin tick(); w++; end
        w = 0;
        while (busy && w < 50) begin tick(); w++; end
        check("frame_end", 32'(busy), 32'd0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (gnt != '0 && w < 100) begin tick(); w++; end
        check("gnt_idle", 32'(gnt), 32'd0);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        int e;
        logic [3:0] oh;
        req_valid = v.mask;
        req_data  = v.data;
        req_last  = v.mask;
        for (int k = 0; k < v.n; k++) begin
            wait_en(100, w);
            if (k == 0) check("vec_latency", 32'(w), 32'd1);
            e  = int'(v.order[4*k +: 4]);
            oh = 4'b0001 << e;
            check("vec_gnt", 32'(gnt), 32'(oh));
            check("vec_ready", 32'(req_ready), 32'(oh));
            check("vec_data", 32'(uart_tx_data), 32'(v.data[8*e +: 8]));
            req_valid = req_valid & ~oh;
        end
        wait_idle();
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (spos[i] < slen[i] && sgap[i] == 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = str_data[i][spos[i]];
                req_last[i]        = str_last[i][spos[i]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // Reference: serve whole packets round-robin among requesters that still
    // have packets, starting after the previous owner.
    task automatic build_model();
        int mp [N];
        int p;
        int found;
        int c;
        bit last;
        for (int i = 0; i < N; i++) mp[i] = 0;
        p = 0;
        n_exp = 0;
        while (1) begin
            found = -1;
            for (int o = 0; o < N; o++) begin
                c = (p + o) % N;
                if (found < 0 && mp[c] < slen[c]) found = c;
            end
            if (found < 0) break;
            do begin
                exp_idx[n_exp]  = found;
                exp_data[n_exp] = str_data[found][mp[found]];
                last = str_last[found][mp[found]];
                mp[found]++;
                n_exp++;
            end while (!last);
            p = (found + 1) % N;
        end
    endtask

    task automatic random_round();
        int np;
        int len;
        int k;
        int w;
        logic [3:0] oh;
        for (int i = 0; i < N; i++) begin
            slen[i] = 0;
            np = int'($urandom_range(3, 0));
            for (int pk = 0; pk < np; pk++) begin
                len = int'($urandom_range(3, 1));
                for (int b = 0; b < len; b++) begin
                    str_data[i][slen[i]] = 8'($urandom);
                    str_last[i][slen[i]] = (b == len - 1);
                    slen[i]++;
                end
            end
            spos[i] = 0;
            sgap[i] = 0;
        end
        build_model();
        reset_dut();
        present();
        k = 0;
        w = 0;
        lt_seen = 0;
        while (!(k == n_exp && gnt == '0) && w < 4000) begin
            tick();
            w++;
            if (uart_tx_en) begin
                if (k < n_exp) begin
                    oh = 4'b0001 << exp_idx[k];
                    check("rand_gnt", 32'(gnt), 32'(oh));
                    check("rand_ready", 32'(req_ready), 32'(oh));
                    check("rand_data", 32'(uart_tx_data), 32'(exp_data[k]));
                    k++;
                end else begin
                    check("rand_extra_en", 32'(uart_tx_en), 32'd0);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    sgap[i] = str_last[i][spos[i]] ? 0 : int'($urandom_range(3, 0));
                    spos[i]++;
                end else if (sgap[i] > 0) begin
                    sgap[i]--;
                end
            end
            present();
        end
        check("rand_bytes", 32'(k), 32'(n_exp));
        check("rand_lock", 32'(lt_seen), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{4'b1111, 32'h44332211, 4, 16'h3210};
        vecs[1] = '{4'b0001, 32'h000000E0, 1, 16'h0000};
        vecs[2] = '{4'b0100, 32'h00A50000, 1, 16'h0002};
        vecs[3] = '{4'b1111, 32'hD4C3B2A1, 4, 16'h2103};
        vecs[4] = '{4'b0011, 32'h00009A89, 2, 16'h0010};
        vecs[5] = '{4'b1001, 32'h7E00005D, 2, 16'h0003};
        vecs[6] = '{4'b0101, 32'h00F100C8, 2, 16'h0002};
        vecs[7] = '{4'b1110, 32'h3B2A1900, 3, 16'h0321};

        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_en", 32'(uart_tx_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_lock", 32'(lock_timeout), 32'd0);
        reset_dut();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Three-byte packet from requester 1 while requester 0 waits.
        req_valid = 4'b0010;
        req_data  = 32'h00001100;
        req_last  = 4'b0000;
        wait_en(100, w);
        check("pkt_lat", 32'(w), 32'd1);
        check("pkt_b0_gnt", 32'(gnt), 32'h2);
        check("pkt_b0_data", 32'(uart_tx_data), 32'h11);
        req_data  = 32'h00002244;
        req_valid = 4'b0011;
        req_last  = 4'b0001;
        wait_frame();
        wait_en(100, w);
        check("pkt_b1_gap", 32'(w), 32'd2);
        check("pkt_b1_gnt", 32'(gnt), 32'h2);
        check("pkt_b1_data", 32'(uart_tx_data), 32'h22);
        req_data = 32'h00003344;
        req_last = 4'b0011;
        wait_frame();
        wait_en(100, w);
        check("pkt_b2_gap", 32'(w), 32'd2);
        check("pkt_b2_gnt", 32'(gnt), 32'h2);
        check("pkt_b2_data", 32'(uart_tx_data), 32'h33);
        req_valid = 4'b0001;
        wait_frame();
        wait_en(100, w);
        check("pkt_next_gap", 32'(w), 32'd2);
        check("pkt_next_gnt", 32'(gnt), 32'h1);
        check("pkt_next_data", 32'(uart_tx_data), 32'h44);
        req_valid = 4'b0000;
        wait_idle();

        // Owner 3 stalls after a non-last byte; requester 0 is pending.
        req_valid = 4'b1000;
        req_data  = 32'h3C000000;
        req_last  = 4'b0000;
        wait_en(100, w);
        check("to_gnt", 32'(gnt), 32'h8);
        req_valid = 4'b0001;
        req_data  = 32'h0000000F;
        req_last  = 4'b0001;
        wait_frame();
        lt_seen = 0;
        repeat (8) tick();
        check("to_hold_gnt", 32'(gnt), 32'h8);
        check("to_hold_pulse", 32'(lt_seen), 32'd0);
        tick();
        check("to_pulse", 32'(lock_timeout), 32'd1);
        check("to_gnt_clr", 32'(gnt), 32'd0);
        tick();
        check("to_pulse_end", 32'(lock_timeout), 32'd0);
        check("to_next_en", 32'(uart_tx_en), 32'd1);
        check("to_next_gnt", 32'(gnt), 32'h1);
        check("to_next_data", 32'(uart_tx_data), 32'h0F);
        req_valid = 4'b0000;
        wait_idle();
        check("to_pulses", 32'(lt_seen), 32'd1);

        // Owner valid returns on the final hold cycle: byte wins, no timeout.
        req_valid = 4'b0100;
        req_data  = 32'h005A0000;
        req_last  = 4'b0000;
        wait_en(100, w);
        check("race_gnt", 32'(gnt), 32'h4);
        req_valid = 4'b0000;
        req_data  = 32'h00C30000;
        req_last  = 4'b0100;
        wait_frame();
        lt_seen = 0;
        repeat (7) tick();
        check("race_hold_gnt", 32'(gnt), 32'h4);
        tick();
        req_valid = 4'b0100;
        tick();
        check("race_en", 32'(uart_tx_en), 32'd1);
        check("race_data", 32'(uart_tx_data), 32'hC3);
        req_valid = 4'b0000;
        wait_idle();
        check("race_no_pulse", 32'(lt_seen), 32'd0);

        // Asynchronous reset while in WAIT_DONE of a 2-byte packet.
        req_valid = 4'b0010;
        req_data  = 32'h00007700;
        req_last  = 4'b0000;
        wait_en(100, w);
        check("rstmid_data", 32'(uart_tx_data), 32'h77);
        req_data = 32'h00008800;
        req_last = 4'b0010;
        w = 0;
        while (!busy && w < 10) begin tick(); w++; end
        tick();
        check("rstmid_pre_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        check("rstmid_gnt", 32'(gnt), 32'd0);
        check("rstmid_en", 32'(uart_tx_en), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd0);
        check("rstmid_txdata", 32'(uart_tx_data), 32'd0);
        check("rstmid_lock", 32'(lock_timeout), 32'd0);
        req_valid = 4'b1100;
        req_data  = 32'h63620000;
        req_last  = 4'b1100;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_en(100, w);
        check("rstmid_lat", 32'(w), 32'd1);
        check("rstmid_gnt2", 32'(gnt), 32'h4);
        check("rstmid_data2", 32'(uart_tx_data), 32'h62);
        req_valid = 4'b1000;
        wait_en(100, w);
        check("rstmid_gnt3", 32'(gnt), 32'h8);
        check("rstmid_data3", 32'(uart_tx_data), 32'h63);
        req_valid = 4'b0000;
        wait_idle();

        for (int r = 0; r < 4; r++) random_round();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
